// File: rtl/iv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iv_pkg
//  Purpose  : Shared definitions for the 128-bit Galois IV sequence: width,
//             feedback taps, checker FSM states and the bit-exact step
//             function iv_next() used by the generator, the checker and its
//             testbench model.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package iv_pkg;

    localparam int IV_W     = 128;
    localparam int IV_NTAPS = 3;
    localparam int IV_TAPS [IV_NTAPS] = '{99, 101, 104};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Bit mask of the tap positions, built from IV_TAPS so the two never
    // disagree.
    function automatic logic [IV_W-1:0] iv_tap_mask();
        logic [IV_W-1:0] m;
        m = '0;
        for (int k = 0; k < IV_NTAPS; k++) begin
            m = m | ({{(IV_W-1){1'b0}}, 1'b1} << IV_TAPS[k]);
        end
        return m;
    endfunction

    localparam logic [IV_W-1:0] IV_TAP_MASK = iv_tap_mask();

    // One Galois step: rotate left by one; when the feedback bit is set the
    // tap positions take the inverted old bit instead of the shifted bit.
    function automatic logic [IV_W-1:0] iv_next(input logic [IV_W-1:0] c);
        logic            fb;
        logic [IV_W-1:0] shifted;
        fb      = c[IV_W-1];
        shifted = {c[IV_W-2:0], fb};
        if (fb) begin
            return (shifted & ~IV_TAP_MASK) | (~c & IV_TAP_MASK);
        end
        return shifted;
    endfunction

endpackage : iv_pkg
`default_nettype wire

// File: rtl/iv_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : iv_predictor
//  Purpose  : Holds the predicted next IV. 'load' seeds the prediction from
//             the observed sample, 'step' advances the prediction by one
//             generator step. 'match' compares the observed sample against
//             the current prediction combinationally.
//  Ports    : clk, rst_n        clock, async active-low reset
//             load, step        seed from iv_in / free-run advance (load wins)
//             iv_in[127:0]      observed IV
//             match             iv_in equals current prediction
//  Revision : 1.0  initial release
// ============================================================================
module iv_predictor
    import iv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [IV_W-1:0] iv_in,
    output logic            match
);

    logic [IV_W-1:0] r_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred <= '0;
        end else if (load) begin
            r_pred <= iv_next(iv_in);
        end else if (step) begin
            r_pred <= iv_next(r_pred);
        end
    end

    assign match = (iv_in == r_pred);

endmodule : iv_predictor
`default_nettype wire

// File: rtl/iv_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : iv_sequence_checker
//  Purpose  : Receive-side checker for the Galois IV stream. Self-seeds a
//             predictor from incoming samples (HUNT -> VERIFY), declares lock
//             after LOCK_CNT consecutive correct predictions, and in LOCKED
//             counts mismatches and sync losses in saturating counters.
//  Ports    : clk, rst_n        clock, async active-low reset
//             in_valid, iv_in   observed IV sample (no backpressure)
//             clear_stats       synchronous clear of err_count/loss_count
//             chk_valid         1 cycle after each in_valid
//             chk_match         sample equalled the prediction
//             locked, state     FSM status (HUNT=0, VERIFY=1, LOCKED=2)
//             err_count         mismatches while LOCKED (saturating)
//             loss_count        LOCKED -> VERIFY transitions (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module iv_sequence_checker
    import iv_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IV_W-1:0]  iv_in,
    input  logic             clear_stats,
    output logic             chk_valid,
    output logic             chk_match,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] loss_count
);

    // The 4-bit run counters limit both thresholds to 1..15.
    generate
        if (LOCK_CNT < 1 || LOCK_CNT > 15 || LOSS_CNT < 1 || LOSS_CNT > 15 || CNT_W < 1) begin : g_param_check
            $error("iv_sequence_checker: LOCK_CNT/LOSS_CNT must be 1..15 and CNT_W >= 1");
        end
    endgenerate

    localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [3:0] c_loss_cnt = 4'(LOSS_CNT);

    state_t     r_state;
    logic [3:0] r_good_cnt;
    logic [3:0] r_bad_cnt;

    logic       w_match;
    logic       w_zero;
    logic [3:0] w_good_inc;
    logic [3:0] w_bad_inc;
    logic       w_lock_hit;
    logic       w_loss_hit;
    logic       w_load;
    logic       w_step;
    logic       w_err_inc;
    logic       w_loss_inc;

    iv_predictor u_predictor (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .iv_in (iv_in),
        .match (w_match)
    );

    assign w_zero     = (iv_in == '0);
    assign w_good_inc = r_good_cnt + 4'd1;
    assign w_bad_inc  = r_bad_cnt + 4'd1;
    assign w_lock_hit = (w_good_inc == c_lock_cnt);
    assign w_loss_hit = (w_bad_inc == c_loss_cnt);

    // Predictor controls and statistic increments for the current sample.
    always_comb begin
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_err_inc  = 1'b0;
        w_loss_inc = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    // All-zero is the generator's lockup value; never seed from it.
                    w_load = !w_zero;
                end
                VERIFY: begin
                    if (w_match) begin
                        w_step = 1'b1;
                    end else begin
                        w_load = !w_zero;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_step = 1'b1;
                    end else begin
                        w_err_inc = 1'b1;
                        if (w_loss_hit) begin
                            w_loss_inc = 1'b1;
                            w_load     = 1'b1;
                        end else begin
                            // Free-run past an isolated bad sample.
                            w_step = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            chk_valid  <= 1'b0;
            chk_match  <= 1'b0;
            err_count  <= '0;
            loss_count <= '0;
        end else begin
            chk_valid <= in_valid;
            chk_match <= in_valid && w_match && (r_state != HUNT);

            // Clear takes priority over a coincident increment.
            if (clear_stats) begin
                err_count <= '0;
            end else if (w_err_inc && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end

            if (clear_stats) begin
                loss_count <= '0;
            end else if (w_loss_inc && (loss_count != '1)) begin
                loss_count <= loss_count + 1'b1;
            end

            if (in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (!w_zero) begin
                            r_good_cnt <= '0;
                            r_state    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_match) begin
                            r_good_cnt <= w_good_inc;
                            if (w_lock_hit) begin
                                r_state   <= LOCKED;
                                r_bad_cnt <= '0;
                            end
                        end else if (!w_zero) begin
                            r_good_cnt <= '0;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_bad_cnt <= '0;
                        end else begin
                            r_bad_cnt <= w_bad_inc;
                            if (w_loss_hit) begin
                                r_good_cnt <= '0;
                                r_state    <= VERIFY;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

    assign state  = r_state;
    assign locked = (r_state == LOCKED);

endmodule : iv_sequence_checker
`default_nettype wire

// File: tb/tb_iv_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iv_sequence_checker
//  Purpose  : Directed, self-checking testbench for iv_sequence_checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iv_sequence_checker;
    import iv_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] iv_in = '0;
    logic         clear_stats = 1'b0;
    logic         chk_valid;
    logic         chk_match;
    logic         locked;
    logic [1:0]   state;
    logic [31:0]  err_count;
    logic [31:0]  loss_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_iv;

    iv_sequence_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .iv_in       (iv_in),
        .clear_stats (clear_stats),
        .chk_valid   (chk_valid),
        .chk_match   (chk_match),
        .locked      (locked),
        .state       (state),
        .err_count   (err_count),
        .loss_count  (loss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one valid sample; returns 1 time unit after the capturing edge.
    task automatic send(input logic [127:0] v, input logic clr = 1'b0);
        @(negedge clk);
        in_valid    = 1'b1;
        iv_in       = v;
        clear_stats = clr;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({chk_valid, chk_match, locked, state} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {chk_valid, chk_match, locked, state});
        else n_pass++;
        n_checks++;
        if ({err_count, loss_count} !== 64'd0)
            $display("FAIL reset_counters: got err=%0d loss=%0d expected 0/0", err_count, loss_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Seeds from 1 and walks 2,4,8,16: lock after the 5th sample.
    task automatic test_lock_acquire();
        logic [1:0] es [5];
        logic       em [5];
        es = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        em = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send(128'd1 << i);
            n_checks++;
            if ({chk_valid, chk_match, state} !== {1'b1, em[i], es[i]})
                $display("FAIL lock_acquire[%0d]: got v=%b m=%b st=%0d expected v=1 m=%b st=%0d",
                         i, chk_valid, chk_match, state, em[i], es[i]);
            else n_pass++;
            n_checks++;
            if (locked !== (i == 4))
                $display("FAIL lock_acquire_locked[%0d]: got %b expected %b", i, locked, (i == 4));
            else n_pass++;
        end
        exp_iv = 128'd32;
    endtask

    // Walk the single bit to the MSB, then the feedback step must hit the taps.
    task automatic test_tap_feedback();
        int misses;
        misses = 0;
        for (int k = 5; k < 128; k++) begin
            send(128'd1 << k);
            if (chk_match !== 1'b1 || locked !== 1'b1) misses++;
        end
        n_checks++;
        if (misses != 0) $display("FAIL tap_walk: got %0d misses expected 0", misses);
        else n_pass++;
        send(128'h00000128_00000000_00000000_00000001);
        n_checks++;
        if ({chk_match, locked} !== 2'b11)
            $display("FAIL tap_feedback: got m=%b l=%b expected m=1 l=1", chk_match, locked);
        else n_pass++;
        exp_iv = iv_next(128'h00000128_00000000_00000000_00000001);
    endtask

    task automatic test_single_error();
        send(exp_iv ^ 128'd1);
        exp_iv = iv_next(exp_iv);
        n_checks++;
        if ({chk_match, locked, err_count} !== {1'b0, 1'b1, 32'd1})
            $display("FAIL single_error: got m=%b l=%b err=%0d expected m=0 l=1 err=1", chk_match, locked, err_count);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            send(exp_iv);
            exp_iv = iv_next(exp_iv);
            n_checks++;
            if ({chk_match, locked, err_count} !== {1'b1, 1'b1, 32'd1})
                $display("FAIL single_error_recover[%0d]: got m=%b l=%b err=%0d expected m=1 l=1 err=1",
                         i, chk_match, locked, err_count);
            else n_pass++;
        end
    endtask

    task automatic test_sync_loss();
        logic [127:0] wrong;
        wrong = '0;
        for (int i = 0; i < 3; i++) begin
            wrong  = exp_iv ^ 128'd2;
            send(wrong);
            exp_iv = iv_next(exp_iv);
            n_checks++;
            if ({chk_match, locked} !== {1'b0, (i < 2)})
                $display("FAIL sync_loss[%0d]: got m=%b l=%b expected m=0 l=%b", i, chk_match, locked, (i < 2));
            else n_pass++;
        end
        n_checks++;
        if ({state, loss_count, err_count} !== {2'd1, 32'd1, 32'd4})
            $display("FAIL sync_loss_stats: got st=%0d loss=%0d err=%0d expected st=1 loss=1 err=4",
                     state, loss_count, err_count);
        else n_pass++;
        exp_iv = iv_next(wrong);
        for (int i = 0; i < 4; i++) begin
            send(exp_iv);
            exp_iv = iv_next(exp_iv);
            n_checks++;
            if ({chk_match, state} !== {1'b1, (i == 3) ? 2'd2 : 2'd1})
                $display("FAIL relock[%0d]: got m=%b st=%0d expected m=1 st=%0d",
                         i, chk_match, state, (i == 3) ? 2 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_hunt_zero();
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            send(128'd0);
            n_checks++;
            if ({chk_valid, chk_match, state} !== {1'b1, 1'b0, 2'd0})
                $display("FAIL hunt_zero[%0d]: got v=%b m=%b st=%0d expected v=1 m=0 st=0",
                         i, chk_valid, chk_match, state);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) send(128'd1 << i);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL hunt_zero_relock: got %b expected 1", locked);
        else n_pass++;
        exp_iv = 128'd32;
    endtask

    task automatic test_clear_collision();
        send(exp_iv ^ 128'd1);
        exp_iv = iv_next(exp_iv);
        n_checks++;
        if (err_count !== 32'd1) $display("FAIL clear_pre: got err=%0d expected 1", err_count);
        else n_pass++;
        send(exp_iv ^ 128'd1, 1'b1);
        exp_iv = iv_next(exp_iv);
        n_checks++;
        if ({err_count, state, chk_match} !== {32'd0, 2'd2, 1'b0})
            $display("FAIL clear_collision: got err=%0d st=%0d m=%b expected err=0 st=2 m=0",
                     err_count, state, chk_match);
        else n_pass++;
        send(exp_iv);
        exp_iv = iv_next(exp_iv);
        n_checks++;
        if ({chk_match, locked, err_count} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL clear_after: got m=%b l=%b err=%0d expected m=1 l=1 err=0", chk_match, locked, err_count);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [127:0] seq [5];
        logic [1:0]   es  [5];
        seq = '{128'hA5, 128'h14A, 128'h294, 128'h528, 128'hA50};
        es  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        send(exp_iv ^ 128'd1);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            n_checks++;
            if ({chk_valid, state, err_count} !== {1'b0, 2'd2, 32'd1})
                $display("FAIL gap_locked[%0d]: got v=%b st=%0d err=%0d expected v=0 st=2 err=1",
                         i, chk_valid, state, err_count);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({chk_valid, chk_match, locked, state, err_count, loss_count} !== 69'd0)
            $display("FAIL async_reset: got v=%b m=%b l=%b st=%0d err=%0d loss=%0d expected all 0",
                     chk_valid, chk_match, locked, state, err_count, loss_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(seq[i]);
            n_checks++;
            if ({chk_match, state} !== {(i != 0), es[i]})
                $display("FAIL reseed_a5[%0d]: got m=%b st=%0d expected m=%b st=%0d",
                         i, chk_match, state, (i != 0), es[i]);
            else n_pass++;
            repeat (2) idle_cycle();
            n_checks++;
            if ({chk_valid, state} !== {1'b0, es[i]})
                $display("FAIL reseed_gap[%0d]: got v=%b st=%0d expected v=0 st=%0d", i, chk_valid, state, es[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_tap_feedback();
        test_single_error();
        test_sync_loss();
        test_hunt_zero();
        test_clear_collision();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_iv_sequence_checker
`default_nettype wire

// File: doc/iv_sequence_checker.md
Name: iv_sequence_checker

Overview:
Receive-side companion to the 128-bit Galois IV generator. Takes the IV stream that the AES datapath has consumed and checks that it follows the generator's sequence. It self-synchronizes by seeding an internal predictor from the incoming IVs, then declares lock. Once locked it flags every mismatch and keeps error and sync-loss statistics for the debug/status register block.

Parameters:
LOCK_CNT, 4, consecutive correct predictions (after seeding) needed to enter LOCKED; range 1..15
LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock; range 1..15
CNT_W, 32, width of the saturating statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed
in_valid  in  1  iv_in carries a sample this cycle; the block always accepts, with no backpressure
iv_in  in  128  observed IV
clear_stats  in  1  synchronous clear of err_count and loss_count
chk_valid  out  1  registered; pulses 1 cycle after each in_valid
chk_match  out  1  registered; sample equalled the prediction (qualified by chk_valid)
locked  out  1  state==LOCKED
state  out  2  HUNT=0, VERIFY=1, LOCKED=2
err_count  out  CNT_W  mismatches counted while LOCKED; saturating
loss_count  out  CNT_W  LOCKED->VERIFY transitions; saturating

Behaviour:
- Step function iv_next(c), bit-exact with the generator:
  - fb=c[127]; n[0]=fb; n[i]=c[i-1] for i in 1..127, except i in {99,101,104}.
  - For i in {99,101,104}: n[i] = fb ? ~c[i] : c[i-1].
- Reset (async on rst_n low): state=HUNT; pred=0; good_cnt=0; bad_cnt=0; all outputs 0.
- Nothing changes on cycles with in_valid=0, except clear_stats.
- Latency: chk_valid/chk_match appear 1 cycle after the sample. locked/state update in that same cycle.
- HUNT, on valid:
  - iv_in==0 (lockup value): ignore; stay HUNT; chk_match=0.
  - Otherwise: pred<=iv_next(iv_in); good_cnt<=0; go VERIFY; chk_match=0.
- VERIFY, on valid:
  - Match: good_cnt++; pred<=iv_next(pred). When good_cnt+1==LOCK_CNT, go LOCKED with bad_cnt<=0.
  - Mismatch, nonzero iv_in: reseed pred<=iv_next(iv_in); good_cnt<=0; stay VERIFY.
  - Mismatch, iv_in==0: go HUNT.
- LOCKED, on valid:
  - pred<=iv_next(pred) always; the predictor free-runs so an isolated corrupted sample does not derail it.
  - Match: bad_cnt<=0.
  - Mismatch: err_count++ (saturating); bad_cnt++. When bad_cnt+1==LOSS_CNT: loss_count++; reseed pred<=iv_next(iv_in); good_cnt<=0; go VERIFY.
- Mismatches in HUNT/VERIFY are not counted in err_count.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats coinciding with an increment: clear wins, so the counter reads 0 next cycle. clear_stats does not affect the FSM.
- Reset mid-stream: all state discarded; the next nonzero sample reseeds.
- good_cnt/bad_cnt are 4 bits each; parameter range is checked by an elaboration-time assertion.

Decomposition:
- Package iv_pkg holds:
  - IV_W=128
  - IV_TAPS {99,101,104}
  - state typedef/localparams HUNT/VERIFY/LOCKED
  - function iv_next(). The generator and the checker's testbench model share this function.
- One sub-module, iv_predictor: holds pred, with load/step controls and a combinational compare output. The FSM and counters stay in the top.

Test Plan:
- Reset, then feed 1, 2, 4, 8, 16 (LOCK_CNT=4) -> state HUNT->VERIFY after 1, then locked=1 one cycle after the 5th sample; chk_match=0,1,1,1,1.
- Locked at pred=128'h80000000_00000000_00000000_00000000, feed 128'h00000128_00000000_00000000_00000001 -> chk_match=1, exercising the feedback taps.
- Locked; corrupt one sample (flip bit 0), then continue the true sequence -> one chk_match=0; err_count=1; stays LOCKED; following samples match.
- Locked; 3 consecutive wrong samples -> locked drops after the 3rd; loss_count=1; state=VERIFY; relock after 4 further correct samples seeded from the 3rd.
- Feed iv_in=0 in HUNT -> stays HUNT. Assert clear_stats in the same cycle as a LOCKED mismatch -> err_count=0.
- Pull rst_n low mid-LOCKED with in_valid gaps -> all outputs 0 immediately. Feed a fresh sequence from seed 128'hA5 -> relocks normally; gaps cause no state change.
